// File: rtl/fir_axilite_initiator_if.sv
// Bundle of the command/response port and the AXI-Lite configuration
// bus. "master" is the initiator side; "slave" is the command source
// plus the register responder.
interface fir_axilite_initiator_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pPOLL_WIDTH = 16
);
    // command / response
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [pADDR_WIDTH-1:0] cmd_addr;
    logic [pDATA_WIDTH-1:0] cmd_wdata;
    logic [pPOLL_WIDTH-1:0] cmd_poll_limit;
    logic                   rsp_valid;
    logic [pDATA_WIDTH-1:0] rsp_rdata;
    logic                   rsp_timeout;
    logic                   rsp_err;

    // AXI-Lite
    logic                   awvalid;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   awready;
    logic                   wvalid;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   wready;
    logic                   arvalid;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   arready;
    logic                   rvalid;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   rready;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_poll_limit,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_err,
        output awvalid, awaddr, input awready,
        output wvalid, wdata, input wready,
        output arvalid, araddr, input arready,
        input  rvalid, rdata, output rready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_poll_limit,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_err,
        input  awvalid, awaddr, output awready,
        input  wvalid, wdata, output wready,
        input  arvalid, araddr, output arready,
        output rvalid, rdata, input rready
    );
endinterface

// File: rtl/fir_axilite_initiator.sv
// AXI-Lite initiator for the FIR configuration port: single writes,
// single reads and bounded polling of a status mask, one transaction
// in flight at a time. All outputs are registered.
module fir_axilite_initiator #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pPOLL_WIDTH = 16
) (
    input  logic                    axis_clk,
    input  logic                    axis_rst_n,
    fir_axilite_initiator_if.master bus
);

    typedef enum logic [2:0] {IDLE, WRITE, RADDR, RDATA, GAP, DONE} state_e;
    typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01,
                              OP_POLL = 2'b10, OP_ILLEGAL = 2'b11} op_e;

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [pDATA_WIDTH-1:0] data_q, data_d;      // write data or poll mask
    logic [pPOLL_WIDTH-1:0] cnt_q, cnt_d;        // reads left in a poll
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [pDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic                   rsp_err_q, rsp_err_d;

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.awvalid     = awvalid_q;
    assign bus.awaddr      = addr_q;
    assign bus.wvalid      = wvalid_q;
    assign bus.wdata       = data_q;
    assign bus.arvalid     = arvalid_q;
    assign bus.araddr      = addr_q;
    assign bus.rready      = rready_q;

    // State and output registers, cleared asynchronously.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q       <= IDLE;
            op_q          <= OP_WRITE;
            addr_q        <= '0;
            data_q        <= '0;
            cnt_q         <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d          = op_e'(bus.cmd_op);
                    addr_d        = bus.cmd_addr;
                    data_d        = bus.cmd_wdata;
                    cnt_d         = (bus.cmd_poll_limit == '0) ? pPOLL_WIDTH'(1)
                                                               : bus.cmd_poll_limit;
                    rsp_timeout_d = 1'b0;
                    rsp_err_d     = 1'b0;
                    case (bus.cmd_op)
                        2'b00: begin
                            state_d   = WRITE;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end
                        2'b01, 2'b10: begin
                            state_d   = RADDR;
                            arvalid_d = 1'b1;
                            rready_d  = 1'b1;
                        end
                        default: begin
                            state_d   = DONE;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (awvalid_q && bus.awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)  state_d   = DONE;
            end
            RADDR: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (bus.rvalid) begin
                    rsp_rdata_d = bus.rdata;
                    rready_d    = 1'b0;
                    if (op_q != OP_POLL) begin
                        state_d = DONE;
                    end else if ((bus.rdata & data_q) != '0) begin
                        state_d = DONE;
                    end else if (cnt_q == pPOLL_WIDTH'(1)) begin
                        state_d       = DONE;
                        rsp_timeout_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - pPOLL_WIDTH'(1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d   = RADDR;
                arvalid_d = 1'b1;
                rready_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_fir_axilite_initiator.sv
// Randomized bench for fir_axilite_initiator: a reactive register
// responder with programmable wait states, and a reference model that
// predicts each response from the command and the responder's data.
module tb_fir_axilite_initiator;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_axilite_initiator_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pPOLL_WIDTH(16)) bus ();

    fir_axilite_initiator #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pPOLL_WIDTH(16)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // responder configuration and per-command observations
    int          aw_wait, w_wait, ar_wait, r_wait, ar_d, r_d;
    bit          r_pending;
    int          r_idx;
    logic [31:0] script [16];
    logic [11:0] exp_addr;
    logic [31:0] exp_wdata;
    int          aw_hs, w_hs, ar_hs, r_hs, awv_cyc, wv_cyc;
    int          overlap, addr_bad, rready_bad;
    int          rsp_count = 0;
    int          rsp_cyc;
    logic [31:0] rsp_rdata_s;
    logic        rsp_to_s, rsp_err_s;
    logic [31:0] model_rdata = '0;

    // Responder and monitor: decide readies/rvalid on each falling edge
    // for the following rising edge, and record what the DUT shows.
    initial begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        r_pending   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.awready = 1'b0;
                bus.wready  = 1'b0;
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                r_pending   = 1'b0;
                continue;
            end
            if (bus.rsp_valid) begin
                rsp_count++;
                rsp_cyc     = cyc;
                rsp_rdata_s = bus.rsp_rdata;
                rsp_to_s    = bus.rsp_timeout;
                rsp_err_s   = bus.rsp_err;
            end
            if (bus.awvalid) awv_cyc++;
            if (bus.wvalid)  wv_cyc++;
            if ((bus.awvalid || bus.wvalid) && (bus.arvalid || bus.rready)) overlap++;

            bus.rvalid = 1'b0;
            if (r_pending) begin
                if (r_wait == 0) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = script[r_idx];
                    r_pending  = 1'b0;
                    if (bus.rready) r_hs++;
                    if (bus.araddr !== exp_addr) addr_bad++;
                end else begin
                    r_wait--;
                end
            end

            bus.arready = 1'b0;
            if (bus.arvalid) begin
                if (ar_wait == 0) begin
                    bus.arready = 1'b1;
                    ar_hs++;
                    if (bus.araddr !== exp_addr) addr_bad++;
                    if (!bus.rready) rready_bad++;
                    r_pending = 1'b1;
                    r_wait    = r_d;
                    r_idx     = (ar_hs <= 16) ? ar_hs - 1 : 0;
                    ar_wait   = ar_d;
                end else begin
                    ar_wait--;
                end
            end

            bus.awready = 1'b0;
            if (bus.awvalid) begin
                if (aw_wait == 0) begin
                    bus.awready = 1'b1;
                    aw_hs++;
                    if (bus.awaddr !== exp_addr) addr_bad++;
                end else begin
                    aw_wait--;
                end
            end

            bus.wready = 1'b0;
            if (bus.wvalid) begin
                if (w_wait == 0) begin
                    bus.wready = 1'b1;
                    w_hs++;
                    if (bus.awaddr !== exp_addr || bus.wdata !== exp_wdata) addr_bad++;
                end else begin
                    w_wait--;
                end
            end
        end
    end

    task automatic clear_obs();
        aw_hs = 0; w_hs = 0; ar_hs = 0; r_hs = 0;
        awv_cyc = 0; wv_cyc = 0;
        overlap = 0; addr_bad = 0; rready_bad = 0;
    endtask

    // Issue one command, predict its outcome and compare.
    // hit_at: 1-based read index whose data hits the mask (0 = never).
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wd, input logic [15:0] lim,
                           input int ad, input int wdd, input int ard, input int rd,
                           input int hit_at, input logic [31:0] rd_val);
        int          eff, n, lat, start, c_acc, budget;
        bit          hit;
        logic [31:0] last;
        logic        exp_to, exp_err;

        for (int i = 0; i < 16; i++) begin
            if (op == 2'b01)      script[i] = rd_val;
            else if (i + 1 == hit_at) script[i] = $urandom | wd;
            else                  script[i] = $urandom & ~wd;
        end

        // reference model
        eff = (lim == 0) ? 1 : int'(lim);
        n = 0; hit = 1'b0; last = model_rdata; exp_to = 1'b0; exp_err = 1'b0;
        case (op)
            2'b00: lat = ((ad > wdd) ? ad : wdd) + 2;
            2'b01: begin
                n = 1; last = script[0]; lat = ard + rd + 3;
            end
            2'b10: begin
                while (!hit && n < eff) begin
                    last = script[n];
                    n++;
                    hit = (last & wd) != 0;
                end
                exp_to = !hit;
                lat = n * (ard + rd + 3);
            end
            default: begin
                exp_err = 1'b1; lat = 1;
            end
        endcase

        aw_wait = ad; w_wait = wdd; ar_wait = ard; ar_d = ard; r_d = rd;
        exp_addr = addr; exp_wdata = wd;
        clear_obs();
        start = rsp_count;
        check({tag, " cmd_ready"}, bus.cmd_ready, 1);

        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = op;
        bus.cmd_addr       = addr;
        bus.cmd_wdata      = wd;
        bus.cmd_poll_limit = lim;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        c_acc = cyc;
        budget = 600;
        while (rsp_count == start && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);

        check({tag, " rsp_count"}, rsp_count - start, 1);
        check({tag, " latency"}, rsp_cyc - c_acc + 1, lat);
        check({tag, " rsp_rdata"}, rsp_rdata_s, last);
        check({tag, " rsp_timeout"}, rsp_to_s, exp_to);
        check({tag, " rsp_err"}, rsp_err_s, exp_err);
        check({tag, " aw_hs"}, aw_hs, (op == 2'b00) ? 1 : 0);
        check({tag, " w_hs"}, w_hs, (op == 2'b00) ? 1 : 0);
        check({tag, " awvalid_cycles"}, awv_cyc, (op == 2'b00) ? ad + 1 : 0);
        check({tag, " wvalid_cycles"}, wv_cyc, (op == 2'b00) ? wdd + 1 : 0);
        check({tag, " ar_hs"}, ar_hs, n);
        check({tag, " r_hs"}, r_hs, n);
        check({tag, " addr_data_stable"}, addr_bad, 0);
        check({tag, " rw_overlap"}, overlap, 0);
        check({tag, " rready_at_ar"}, rready_bad, 0);
        model_rdata = last;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " cmd_ready"}, bus.cmd_ready, 1);
        check({tag, " awvalid"}, bus.awvalid, 0);
        check({tag, " wvalid"}, bus.wvalid, 0);
        check({tag, " arvalid"}, bus.arvalid, 0);
        check({tag, " rready"}, bus.rready, 0);
        check({tag, " awaddr"}, 32'(bus.awaddr), 0);
        check({tag, " araddr"}, 32'(bus.araddr), 0);
        check({tag, " wdata"}, bus.wdata, 0);
        check({tag, " rsp_valid"}, bus.rsp_valid, 0);
        check({tag, " rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, " rsp_timeout"}, bus.rsp_timeout, 0);
        check({tag, " rsp_err"}, bus.rsp_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          start, budget, sel;
        logic [1:0]  op;
        logic [31:0] mask;

        rst_n              = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = '0;
        bus.cmd_addr       = '0;
        bus.cmd_wdata      = '0;
        bus.cmd_poll_limit = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed cases
        run_cmd("wr_fast",   2'b00, 12'h020, 32'h0000_0001, 16'd0, 0, 0, 0, 0, 0, '0);
        run_cmd("wr_wslow",  2'b00, 12'h024, 32'hA5A5_1234, 16'd0, 0, 3, 0, 0, 0, '0);
        run_cmd("rd_0x10",   2'b01, 12'h010, 32'h0,         16'd0, 0, 0, 0, 0, 0, 32'h0000_0040);
        run_cmd("poll_hit4", 2'b10, 12'h000, 32'h0000_0002, 16'd10, 0, 0, 0, 0, 4, '0);
        run_cmd("poll_to3",  2'b10, 12'h000, 32'h0000_0002, 16'd3, 0, 0, 0, 0, 0, '0);
        run_cmd("poll_lim0", 2'b10, 12'h000, 32'h0000_0002, 16'd0, 0, 0, 0, 0, 0, '0);
        run_cmd("poll_slow", 2'b10, 12'h004, 32'h0000_0010, 16'd5, 0, 0, 2, 1, 5, '0);
        run_cmd("wr_awslow", 2'b00, 12'h080, 32'hDEAD_BEEF, 16'd0, 2, 0, 0, 0, 0, '0);

        // randomized commands
        for (int k = 0; k < 40; k++) begin
            sel  = $urandom_range(0, 9);
            op   = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            mask = (32'h1 << $urandom_range(0, 31)) |
                   (($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
            run_cmd("rand", op, 12'($urandom_range(0, 1023) * 4),
                    (op == 2'b10) ? mask : $urandom, 16'($urandom_range(0, 6)),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 7), $urandom);
        end

        // reset while waiting for read data
        for (int i = 0; i < 16; i++) script[i] = 32'h0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; ar_d = 0; r_d = 6;
        exp_addr = 12'h008; exp_wdata = 32'h1;
        clear_obs();
        start = rsp_count;
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = 2'b10;
        bus.cmd_addr       = 12'h008;
        bus.cmd_wdata      = 32'h1;
        bus.cmd_poll_limit = 16'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        budget = 20;
        while (!(bus.rready && !bus.arvalid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("rst_mid reached_rdata", bus.rready && !bus.arvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid arvalid", bus.arvalid, 0);
        check("rst_mid rready", bus.rready, 0);
        check("rst_mid awvalid", bus.awvalid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid no_rsp", rsp_count - start, 0);
        check_reset_state("rst_mid");
        model_rdata = '0;

        run_cmd("illegal", 2'b11, 12'h030, 32'h1234_5678, 16'd4, 0, 0, 0, 0, 0, '0);
        run_cmd("rd_after", 2'b01, 12'h034, 32'h0, 16'd0, 1, 1, 1, 1, 0, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_axilite_initiator.md
# fir_axilite_initiator

AXI-Lite initiator (master) that drives the FIR block's AXI-Lite configuration port from a simple command/response interface. It issues single register writes (tap coefficients, data_length, ap_start), single reads, and hardware polling of a status bit (ap_done/ap_idle, x/y ready) with a bounded retry count. It sits between the firmware/user-project command path and the FIR configuration slave, on the same axis_clk domain.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, AXI-Lite data width
- pPOLL_WIDTH, 16, width of the poll retry counter

- axis_clk  in  1  clock
- axis_rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal
- cmd_addr  in  pADDR_WIDTH  target register address
- cmd_wdata  in  pDATA_WIDTH  write data (write) / bit mask (poll)
- cmd_poll_limit  in  pPOLL_WIDTH  max reads for poll; 0 treated as 1
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  pDATA_WIDTH  last read data; held until next read/poll completes
- rsp_timeout  out  1  valid with rsp_valid; poll exhausted without mask hit
- rsp_err  out  1  valid with rsp_valid; illegal opcode
- awvalid, awaddr  out  1, pADDR_WIDTH  write address channel
- awready  in  1
- wvalid, wdata  out  1, pDATA_WIDTH  write data channel
- wready  in  1
- arvalid, araddr  out  1, pADDR_WIDTH  read address channel
- arready  in  1
- rvalid, rdata  in  1, pDATA_WIDTH  read data channel
- rready  out  1

## Operation
- States: IDLE, WRITE, RADDR, RDATA, GAP, DONE.
- IDLE: cmd_ready=1. On accept, latch op, addr, wdata, limit (0->1) into registers; go WRITE (00), RADDR (01, 10), DONE with err (11).
- WRITE: awvalid and wvalid both asserted in the first WRITE cycle with awaddr/wdata from latched command. Each valid drops after its own handshake; awaddr and wdata held stable until both handshakes are complete (responder samples awaddr on the w handshake). Both done -> DONE.
- RADDR: arvalid=1, rready=1 (responder only generates rvalid if rready is high at the ar handshake). ar handshake -> RDATA, arvalid drops.
- RDATA: rready=1, araddr held stable (responder's rdata is combinational on araddr). On rvalid: capture rdata into rsp_rdata.
  - read: -> DONE.
  - poll: if (rdata & mask)!=0 -> DONE, timeout=0; else decrement count; count reaches 0 -> DONE, timeout=1; else -> GAP.
- GAP: one idle cycle, no valids; -> RADDR.
- DONE: rsp_valid=1 for one cycle with rsp_timeout/rsp_err; -> IDLE. rsp_timeout and rsp_err cleared on next command accept.
- No outstanding transactions beyond one; reads and writes never overlap.

## Timing
- Reset: state IDLE, cmd_ready=1, all valids/rready=0, awaddr/araddr/wdata=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, rsp_err=0. Reset mid-transaction drops all valids immediately (async), command lost, no rsp.
- Outputs registered; valids assert the cycle after command accept.
- Write, awready=wready=1: accept edge T0, aw/w valid in T1, rsp_valid in T2.
- Write with awready at T1, wready delayed to T3: awvalid drops after T1, wvalid held to T3, rsp_valid T4.
- Read, arready in T1, rvalid in T2: rsp_valid T3, rsp_rdata updated same cycle.
- Poll iteration period 3 cycles (RADDR, RDATA, GAP) with zero-wait responder.
- Illegal op: rsp_valid with rsp_err=1 one cycle after accept, no bus activity.
- Responder stalls (arready=0, e.g. responder in IDLE) hold state indefinitely; no bus timeout.

## Test plan
- Write 0x020 <- 0x0000_0001 with always-ready slave -> aw/w valid together 1 cycle after accept, awaddr=0x020 stable, rsp_valid 2 cycles after accept, rsp_err=0.
- Write with wready delayed 3 cycles -> awvalid single cycle, wvalid 4 cycles, wdata/awaddr stable throughout, exactly one rsp_valid.
- Read 0x010 returning 0x0000_0040 -> rready high with arvalid, araddr stable until rvalid, rsp_rdata=0x40 at rsp_valid.
- Poll 0x000 mask 0x2, limit 10, responder sets bit1 on 4th read -> exactly 4 ar handshakes, rsp_timeout=0, rsp_rdata bit1=1.
- Poll 0x000 mask 0x2, limit 3, bit never set -> 3 reads, rsp_timeout=1; limit 0 -> 1 read, rsp_timeout=1.
- Assert axis_rst_n low during RDATA -> arvalid/rready 0 immediately, no rsp_valid; op 11 after reset -> rsp_err=1, no valids.
